inst_fetch_unit: RTL and testbench

Multi-cycle fetch sequencer that produces the instruction register's write side.
- On a fetch request from the control unit, it issues a word read to instruction memory over a req/ack handshake.
- It waits a variable number of cycles for the data.
- It then drives a one-cycle IR write strobe with the fetched word, and reports done or error back to the control unit.
- Sits between the main control FSM, the instruction memory port and the instruction register.

---
 rtl/cpu_fetch_pkg.sv | 18 +
 rtl/fetch_timeout_ctr.sv | 31 +++
 rtl/inst_fetch_unit.sv | 125 ++++++++++++
 tb/tb_inst_fetch_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
// Imported by the fetch sequencer and its timeout counter.
package cpu_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE,
    ERR
  } fetch_state_t;

  localparam int INST_W = 32;

  localparam logic [INST_W-1:0] NOP_INST = 32'h00000000;

  localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Counts REQ cycles spent waiting for imem_ack.
// tc flags the last allowed wait cycle.
module fetch_timeout_ctr
  import cpu_fetch_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // Wait counter: cleared on REQ entry, saturates at the terminal count.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tc = (cnt == LAST);

endmodule

// File: rtl/inst_fetch_unit.sv
// Multi-cycle fetch sequencer: imem req/ack handshake to IR write.
// All outputs are registered; error flag is sticky until a good start.
module inst_fetch_unit
  import cpu_fetch_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = INST_W,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_start,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_ack,
  output logic              ir_wr,
  output logic [DATA_W-1:0] inst_out,
  output logic              fetch_done,
  output logic              busy,
  output logic              fetch_err
);

  fetch_state_t state, state_d;

  logic              req_d;
  logic [ADDR_W-1:0] addr_d;
  logic              ir_wr_d;
  logic [DATA_W-1:0] inst_d;
  logic              done_d;
  logic              busy_d;
  logic              err_d;
  logic              ctr_clr;
  logic              ctr_en;
  logic              ctr_tc;

  fetch_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_ctr (
    .clk(clk),
    .rst(rst),
    .clr(ctr_clr),
    .en (ctr_en),
    .tc (ctr_tc)
  );

  // Next state and next register values; strobes default low.
  always_comb begin
    state_d = state;
    req_d   = imem_req;
    addr_d  = imem_addr;
    ir_wr_d = 1'b0;
    inst_d  = inst_out;
    done_d  = 1'b0;
    busy_d  = busy;
    err_d   = fetch_err;
    ctr_clr = 1'b0;
    ctr_en  = 1'b0;
    unique case (state)
      IDLE, ERR: begin
        if (fetch_start) begin
          if (pc_in[1:0] != 2'b00) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            state_d = REQ;
            addr_d  = pc_in;
            req_d   = 1'b1;
            busy_d  = 1'b1;
            err_d   = 1'b0;
            ctr_clr = 1'b1;
          end
        end
      end
      REQ: begin
        if (imem_ack) begin
          state_d = DONE;
          inst_d  = imem_rdata;
          ir_wr_d = 1'b1;
          done_d  = 1'b1;
          req_d   = 1'b0;
        end else if (ctr_tc) begin
          state_d = ERR;
          req_d   = 1'b0;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end else begin
          ctr_en = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      imem_req   <= 1'b0;
      imem_addr  <= '0;
      ir_wr      <= 1'b0;
      inst_out   <= DATA_W'(NOP_INST);
      fetch_done <= 1'b0;
      busy       <= 1'b0;
      fetch_err  <= 1'b0;
    end else begin
      state      <= state_d;
      imem_req   <= req_d;
      imem_addr  <= addr_d;
      ir_wr      <= ir_wr_d;
      inst_out   <= inst_d;
      fetch_done <= done_d;
      busy       <= busy_d;
      fetch_err  <= err_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit (TIMEOUT=4).
// Transaction-level expectations, vector table, random fetches.
module tb_inst_fetch_unit;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_start;
  logic [31:0] pc_in;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic        ir_wr;
  logic [31:0] inst_out;
  logic        fetch_done;
  logic        busy;
  logic        fetch_err;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        ir;
    logic [31:0] inst;
    logic        done;
    logic        busy;
    logic        err;
  } obs_t;

  typedef struct {
    logic [31:0] pc;
    int          w;
    logic [31:0] rdata;
    bit          noise;
    int          exp_req;
    int          exp_ir;
    logic        exp_err;
  } vec_t;

  // Model of the architecturally visible held values.
  logic [31:0] m_addr;
  logic [31:0] m_inst;
  logic        m_err;

  always #5 clk = ~clk;

  inst_fetch_unit #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(T)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_start(fetch_start),
    .pc_in      (pc_in),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .ir_wr      (ir_wr),
    .inst_out   (inst_out),
    .fetch_done (fetch_done),
    .busy       (busy),
    .fetch_err  (fetch_err)
  );

  function automatic obs_t mk(logic req, logic [31:0] addr, logic ir,
                              logic [31:0] inst, logic done, logic bz,
                              logic err);
    obs_t o;
    o.req  = req;
    o.addr = addr;
    o.ir   = ir;
    o.inst = inst;
    o.done = done;
    o.busy = bz;
    o.err  = err;
    return o;
  endfunction

  task automatic check(input string name, input obs_t e);
    obs_t a;
    a = mk(imem_req, imem_addr, ir_wr, inst_out, fetch_done, busy, fetch_err);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got req=%0b addr=%h ir=%0b inst=%h done=%0b busy=%0b err=%0b, want req=%0b addr=%h ir=%0b inst=%h done=%0b busy=%0b err=%0b",
               name, a.req, a.addr, a.ir, a.inst, a.done, a.busy, a.err,
               e.req, e.addr, e.ir, e.inst, e.done, e.busy, e.err);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // One fetch transaction, started at a negedge with the unit in IDLE/ERR.
  // w = REQ cycles without ack before the ack cycle; w >= T means timeout.
  task automatic run_fetch(input logic [31:0] pc, input int w,
                           input logic [31:0] rd, input bit noise,
                           input logic [31:0] npc,
                           output int n_req, output int ir_cyc);
    bit   mis;
    bit   ok;
    bit   live;
    int   last;
    obs_t e;
    mis  = (pc[1:0] != 2'b00);
    ok   = !mis && (w < T);
    last = mis ? 2 : (ok ? w + 3 : T + 2);
    n_req  = 0;
    ir_cyc = 0;
    fetch_start = 1'b1;
    pc_in       = pc;
    imem_ack    = 1'b0;
    imem_rdata  = $urandom;
    for (int j = 1; j <= last; j++) begin
      @(negedge clk);
      if (mis) begin
        e = mk(1'b0, m_addr, 1'b0, m_inst, 1'b0, 1'b0, 1'b1);
      end else if (ok) begin
        if (j <= w + 1)
          e = mk(1'b1, pc, 1'b0, m_inst, 1'b0, 1'b1, 1'b0);
        else if (j == w + 2)
          e = mk(1'b0, pc, 1'b1, rd, 1'b1, 1'b1, 1'b0);
        else
          e = mk(1'b0, pc, 1'b0, rd, 1'b0, 1'b0, 1'b0);
      end else begin
        if (j <= T)
          e = mk(1'b1, pc, 1'b0, m_inst, 1'b0, 1'b1, 1'b0);
        else
          e = mk(1'b0, pc, 1'b0, m_inst, 1'b0, 1'b0, 1'b1);
      end
      check($sformatf("fetch pc=%h w=%0d cyc=%0d", pc, w, j), e);
      if (imem_req) n_req++;
      if (ir_wr && ir_cyc == 0) ir_cyc = j;
      imem_ack   = (j == w + 1);
      imem_rdata = (j == w + 1) ? rd : $urandom;
      live = !mis && (ok ? (j <= w + 2) : (j <= T));
      fetch_start = noise && live;
      pc_in       = noise ? npc : pc;
    end
    fetch_start = 1'b0;
    imem_ack    = 1'b0;
    if (mis) begin
      m_err = 1'b1;
    end else if (ok) begin
      m_addr = pc;
      m_inst = rd;
      m_err  = 1'b0;
    end else begin
      m_addr = pc;
      m_err  = 1'b1;
    end
  endtask

  vec_t vecs[6];

  initial begin
    int n_req;
    int ir_cyc;
    obs_t zero;

    vecs[0] = '{32'h00000040, 0, 32'h8C220004, 1'b0, 1, 2, 1'b0};
    vecs[1] = '{32'h00000044, 3, 32'h00221820, 1'b0, 4, 5, 1'b0};
    vecs[2] = '{32'h00000042, 0, 32'h11111111, 1'b0, 0, 0, 1'b1};
    vecs[3] = '{32'h00000048, 1, 32'h12345678, 1'b0, 2, 3, 1'b0};
    vecs[4] = '{32'h0000004C, 9, 32'h55555555, 1'b0, 4, 0, 1'b1};
    vecs[5] = '{32'h00000040, 2, 32'hAABBCCDD, 1'b1, 3, 4, 1'b0};

    zero        = mk(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    rst         = 1'b1;
    fetch_start = 1'b1;
    pc_in       = 32'h00000040;
    imem_ack    = 1'b1;
    imem_rdata  = 32'hFFFFFFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset state", zero);
    rst         = 1'b0;
    fetch_start = 1'b0;
    imem_ack    = 1'b0;
    @(negedge clk);
    check("idle after reset", zero);
    m_addr = 32'h0;
    m_inst = 32'h0;
    m_err  = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_fetch(vecs[i].pc, vecs[i].w, vecs[i].rdata, vecs[i].noise,
                32'h00000080, n_req, ir_cyc);
      check_int($sformatf("vec%0d req cycles", i), n_req, vecs[i].exp_req);
      check_int($sformatf("vec%0d ir_wr cycle", i), ir_cyc, vecs[i].exp_ir);
      check_int($sformatf("vec%0d fetch_err", i), int'(fetch_err),
                int'(vecs[i].exp_err));
    end

    // Reset in the 2nd REQ cycle while ack arrives: ack is discarded.
    fetch_start = 1'b1;
    pc_in       = 32'h00000040;
    @(negedge clk);
    check("rst mid: req1",
          mk(1'b1, 32'h40, 1'b0, m_inst, 1'b0, 1'b1, 1'b0));
    fetch_start = 1'b0;
    @(negedge clk);
    check("rst mid: req2",
          mk(1'b1, 32'h40, 1'b0, m_inst, 1'b0, 1'b1, 1'b0));
    rst        = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check("rst mid: cleared", zero);
    rst      = 1'b0;
    imem_ack = 1'b0;
    @(negedge clk);
    check("rst mid: stays idle", zero);
    m_addr = 32'h0;
    m_inst = 32'h0;
    m_err  = 1'b0;

    for (int i = 0; i < 40; i++) begin
      logic [31:0] pc;
      pc = $urandom & 32'hFFFFFFFC;
      if ($urandom_range(0, 4) == 0) pc[1:0] = 2'($urandom_range(1, 3));
      run_fetch(pc, $urandom_range(0, T + 2), $urandom,
                bit'($urandom_range(0, 1)), $urandom, n_req, ir_cyc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
